sound_scheduler: RTL and testbench
==================================

// Module: sound_scheduler
// PURPOSE
//  Schedules game sound effects (crash, jump, score) onto one shared sample ROM and one audio_PWM.
//  Generates the internal 8 kHz sample tick and latches one-shot requests from game logic.
//  Arbitrates requests by fixed priority, sequences ROM addresses, converts 4-bit sign-magnitude samples to 8-bit offset-binary music_data.
//  Sits between game FSM (requesters) and audio_PWM.music_data; replaces per-sound timers.
// PARAMETERS
//  CLK_HZ     25_000_000  system clock frequency
//  SAMPLE_HZ  8000        playback rate; DIV = CLK_HZ/SAMPLE_HZ (3125 at defaults)
//  ADDR_W     12          shared sample ROM address width
//  BASE0/1/2  0/1024/2048 ROM base address of source 0 (crash) / 1 (jump) / 2 (score)
//  LEN0/1/2   1024/1024/512  length in samples per source, each >= 2; BASEn+LENn <= 2**ADDR_W
// PORTS
//  clk         in   1       25 MHz system clock
//  reset       in   1       synchronous, active-high
//  snd_req     in   3       per-source request; rising edge = trigger, level ignored
//  rom_data    in   4       combinational ROM read data for rom_addr; bit3 = sign, [2:0] = magnitude
//  rom_addr    out  ADDR_W  registered ROM address
//  music_data  out  8       sample to audio_PWM
//  playing     out  1       1 while a source is being played
//  cur_src     out  2       index of source being played; valid when playing=1
//  done        out  1       1-cycle pulse on natural end of a sound; not asserted on preemption
// BEHAVIOUR
//  Reset: divider=0, req_q=0, pending=0, state=IDLE, rom_addr=0, music_data=8'h80, playing=0, cur_src=0, done=0. Reset mid-playback aborts, no done.
//  Tick: counter 0..DIV-1; tick=1 for one clk when counter==DIV-1; free-running, only reset clears it.
//  Edge detect: req_q<=snd_req each clk; pending[i] set when snd_req[i]&~req_q[i]; cleared when source i starts. Set beats clear on the same clk.
//  Priority: 0 (crash) > 1 (jump) > 2 (score). Sel = lowest-index pending bit.
//  All state changes happen only on tick cycles; between ticks only req_q/pending/divider update.
//  IDLE, tick: music_data<=8'h80. If any pending: START(sel) -> PLAY.
//  START(s): cur_src<=s, offset<=0, rom_addr<=BASEs, pending[s]<=0, playing<=1.
//  PLAY, tick, in order:
//   1) music_data <= conv(rom_data) (sample at current rom_addr).
//   2) If pending sel has priority >= cur_src (incl. same-source retrigger): START(sel); no done.
//   3) Else if offset==LEN[cur_src]-1: done<=1; if any pending START(sel) (gapless chain) else state<=IDLE, playing<=0.
//   4) Else offset<=offset+1, rom_addr<=rom_addr+1.
//  conv(d) = d[3] ? 8'h80-{d[2:0],4'b0} : 8'h80+{d[2:0],4'b0}; range 8'h10..8'hF0, no overflow. d=4'b1000 (negative zero) gives 8'h80.
//  Latency: trigger edge -> START at next tick (<= DIV clks); first sample on music_data one tick after START. A sound occupies LEN ticks; last sample held one tick, then 8'h80 if idle.
//  Pending lower-priority requests wait through a preemption; the preempted sound is dropped, not resumed.
// STRUCTURE
//  Package sound_pkg: SRC_CRASH=0, SRC_JUMP=1, SRC_SCORE=2, NUM_SRC=3, MIDSCALE=8'h80, state encoding {IDLE, PLAY}.
//  Sub-module sample_tick_gen #(DIV) (clk, reset, tick): the divider only.
//  Priority select, sign-magnitude conversion and base/length lookup stay inline.
// TESTING (bench CLK_HZ=80_000, SAMPLE_HZ=8000 -> DIV=10; LEN0/1/2=8/6/4)
//  1 Single jump: 1-clk pulse snd_req[1] -> within 10 clks playing=1, cur_src=1, rom_addr=1024; addresses 1024..1029 on successive ticks;
//    done pulses once on 6th tick; next tick music_data=8'h80, playing=0.
//  2 Conversion: ROM words 4'b0111, 4'b1111, 4'b0000, 4'b1000 -> music_data 8'hF0, 8'h10, 8'h80, 8'h80.
//  3 Preemption: jump at offset 3, pulse snd_req[0] -> next tick cur_src=0, rom_addr=0; no done for jump; crash plays all 8 samples.
//  4 Queued + gapless: crash playing, pulse snd_req[2] -> score starts on crash's end tick (done=1 same clk); no 8'h80 sample between sounds.
//  5 Simultaneous snd_req=3'b111 -> play order crash, jump, score; done pulses 3 times; playing stays 1 throughout.
//  6 snd_req[1] held high 100 clks -> exactly one jump. Re-pulse mid-jump -> restart at 1024.
//    Assert reset mid-play -> next clk playing=0, music_data=8'h80, rom_addr=0, pending=0.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared constants and state encoding for the sound scheduler.
package sound_pkg;

    localparam logic [1:0] SRC_CRASH = 2'd0;
    localparam logic [1:0] SRC_JUMP  = 2'd1;
    localparam logic [1:0] SRC_SCORE = 2'd2;
    localparam int         NUM_SRC   = 3;
    localparam logic [7:0] MIDSCALE  = 8'h80;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

endpackage

// File: rtl/sound_scheduler_tick_gen.sv
// Free-running sample-rate divider: one-clock tick every DIV clocks.
module sample_tick_gen #(
    parameter int DIV = 3125
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Count 0..DIV-1 and wrap; only reset disturbs the phase.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/sound_scheduler.sv
// Fixed-priority sound effect scheduler feeding one shared sample ROM
// and one PWM. Requests are edge-triggered and latched until started.
//
// state | meaning
// IDLE  | no sound playing, music_data parked at midscale
// PLAY  | stepping through the ROM range of cur_src, one sample per tick
module sound_scheduler
    import sound_pkg::*;
#(
    parameter int CLK_HZ    = 25_000_000,
    parameter int SAMPLE_HZ = 8000,
    parameter int ADDR_W    = 12,
    parameter int BASE0     = 0,
    parameter int BASE1     = 1024,
    parameter int BASE2     = 2048,
    parameter int LEN0      = 1024,
    parameter int LEN1      = 1024,
    parameter int LEN2      = 512
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        snd_req,
    input  logic [3:0]        rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        music_data,
    output logic              playing,
    output logic [1:0]        cur_src,
    output logic              done
);

    localparam int DIV = CLK_HZ / SAMPLE_HZ;

    logic               tick;
    logic [NUM_SRC-1:0] req_q;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] pend_set;
    logic [NUM_SRC-1:0] pend_clr;
    logic               any_pend;
    logic [1:0]         sel;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  offset, offset_nxt;
    logic [ADDR_W-1:0]  rom_addr_nxt;
    logic [7:0]         music_nxt;
    logic               playing_nxt;
    logic [1:0]         cur_src_nxt;
    logic               done_nxt;
    logic               start;

    logic [7:0]         mag;
    logic [7:0]         conv_sample;
    logic [ADDR_W-1:0]  last_off;
    logic [ADDR_W-1:0]  sel_base;

    sample_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Edge detect and request latch; a new edge wins over a same-cycle start.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= '0;
            pending <= '0;
        end else begin
            req_q   <= snd_req;
            pending <= (pending & ~pend_clr) | pend_set;
        end
    end

    assign pend_set = snd_req & ~req_q;
    assign any_pend = |pending;

    // Lowest index wins: crash over jump over score.
    always_comb begin
        sel = SRC_CRASH;
        if (pending[0]) begin
            sel = SRC_CRASH;
        end else if (pending[1]) begin
            sel = SRC_JUMP;
        end else if (pending[2]) begin
            sel = SRC_SCORE;
        end
    end

    // Sign-magnitude ROM word to offset-binary; range stays within 10h..F0h.
    always_comb begin
        mag         = {1'b0, rom_data[2:0], 4'b0000};
        conv_sample = rom_data[3] ? (MIDSCALE - mag) : (MIDSCALE + mag);
    end

    // Base address of the source about to start, last offset of the one playing.
    always_comb begin
        case (sel)
            SRC_CRASH: sel_base = ADDR_W'(BASE0);
            SRC_JUMP:  sel_base = ADDR_W'(BASE1);
            default:   sel_base = ADDR_W'(BASE2);
        endcase
        case (cur_src)
            SRC_CRASH: last_off = ADDR_W'(LEN0 - 1);
            SRC_JUMP:  last_off = ADDR_W'(LEN1 - 1);
            default:   last_off = ADDR_W'(LEN2 - 1);
        endcase
    end

    // Playback state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            offset     <= '0;
            rom_addr   <= '0;
            music_data <= MIDSCALE;
            playing    <= 1'b0;
            cur_src    <= SRC_CRASH;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            offset     <= offset_nxt;
            rom_addr   <= rom_addr_nxt;
            music_data <= music_nxt;
            playing    <= playing_nxt;
            cur_src    <= cur_src_nxt;
            done       <= done_nxt;
        end
    end

    // Next-state logic; everything moves only on a sample tick.
    always_comb begin
        state_nxt    = state;
        offset_nxt   = offset;
        rom_addr_nxt = rom_addr;
        music_nxt    = music_data;
        playing_nxt  = playing;
        cur_src_nxt  = cur_src;
        done_nxt     = 1'b0;
        start        = 1'b0;
        pend_clr     = '0;

        if (tick) begin
            case (state)
                IDLE: begin
                    music_nxt = MIDSCALE;
                    if (any_pend) begin
                        start = 1'b1;
                    end
                end
                PLAY: begin
                    music_nxt = conv_sample;
                    if (any_pend && (sel <= cur_src)) begin
                        // Equal or higher priority preempts; includes retrigger.
                        start = 1'b1;
                    end else if (offset == last_off) begin
                        done_nxt = 1'b1;
                        if (any_pend) begin
                            start = 1'b1;
                        end else begin
                            state_nxt   = IDLE;
                            playing_nxt = 1'b0;
                        end
                    end else begin
                        offset_nxt   = offset + 1'b1;
                        rom_addr_nxt = rom_addr + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end

        if (start) begin
            state_nxt    = PLAY;
            cur_src_nxt  = sel;
            offset_nxt   = '0;
            rom_addr_nxt = sel_base;
            playing_nxt  = 1'b1;
            pend_clr     = 3'b001 << sel;
        end
    end

endmodule

// File: tb/tb_sound_scheduler.sv
// Self-checking bench for sound_scheduler with a 10-clock sample period.
module tb_sound_scheduler;

    localparam int ADDR_W = 12;
    localparam int DIV    = 10;

    logic              clk;
    logic              reset;
    logic [2:0]        snd_req;
    logic [3:0]        rom_data;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        music_data;
    logic              playing;
    logic [1:0]        cur_src;
    logic              done;

    logic [3:0] rom_mem [0:4095];
    assign rom_data = rom_mem[rom_addr];

    sound_scheduler #(
        .CLK_HZ    (80_000),
        .SAMPLE_HZ (8000),
        .ADDR_W    (ADDR_W),
        .BASE0     (0),
        .BASE1     (1024),
        .BASE2     (2048),
        .LEN0      (8),
        .LEN1      (6),
        .LEN2      (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .snd_req    (snd_req),
        .rom_data   (rom_data),
        .rom_addr   (rom_addr),
        .music_data (music_data),
        .playing    (playing),
        .cur_src    (cur_src),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int base_t [3] = '{0, 1024, 2048};
    int len_t  [3] = '{8, 6, 4};

    // Bench's own view of the sample phase, reset in lockstep with the DUT.
    int tb_div;
    always @(posedge clk) begin
        if (reset) tb_div <= 0;
        else if (tb_div == DIV - 1) tb_div <= 0;
        else tb_div <= tb_div + 1;
    end

    int done_cnt = 0;
    always @(posedge clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  src;
        logic        playing;
        logic [7:0]  music;
        logic        done;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [3:0] word;
        logic [7:0] music;
    } conv_vec_t;
    conv_vec_t tbl [8];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [7:0] ref_conv(input logic [3:0] d);
        int m, v;
        m = int'(d[2:0]);
        v = d[3] ? (128 - 16 * m) : (128 + 16 * m);
        return 8'(v);
    endfunction

    function automatic logic [7:0] rom_conv(input int a);
        return ref_conv(rom_mem[a]);
    endfunction

    // Return at the negedge following the next tick edge.
    task automatic wait_tick();
        int guard = 0;
        while (tb_div != DIV - 1 && guard < 3 * DIV) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 3 * DIV) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_tick: no tick within %0d clocks", 3 * DIV);
        end
        @(negedge clk);
    endtask

    task automatic pulse(input logic [2:0] mask);
        snd_req = mask;
        @(negedge clk);
        snd_req = 3'b000;
    endtask

    task automatic push(input int addr, input int src, input logic pl, input logic [7:0] mus, input logic dn);
        exp_t e;
        e.addr = 12'(addr); e.src = 2'(src); e.playing = pl; e.music = mus; e.done = dn;
        sb.push_back(e);
    endtask

    task automatic push_start(input int s, input logic [7:0] mus, input logic dn);
        push(base_t[s], s, 1'b1, mus, dn);
    endtask

    task automatic push_body(input int s, input int k0, input int k1);
        for (int k = k0; k <= k1; k++)
            push(base_t[s] + k, s, 1'b1, rom_conv(base_t[s] + k - 1), 1'b0);
    endtask

    function automatic logic [7:0] last_mus(input int s);
        return rom_conv(base_t[s] + len_t[s] - 1);
    endfunction

    task automatic push_end_idle(input int s);
        push(base_t[s] + len_t[s] - 1, s, 1'b0, last_mus(s), 1'b1);
    endtask

    task automatic push_idle(input int addr, input int src, input int n);
        for (int k = 0; k < n; k++) push(addr, src, 1'b0, 8'h80, 1'b0);
    endtask

    task automatic check_ticks(input string tag, input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            wait_tick();
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s t%0d: scoreboard empty, got addr %0h", tag, k, rom_addr);
            end else begin
                e = sb.pop_front();
                chk($sformatf("%s t%0d rom_addr", tag, k), 32'(rom_addr), 32'(e.addr));
                chk($sformatf("%s t%0d cur_src", tag, k), 32'(cur_src), 32'(e.src));
                chk($sformatf("%s t%0d playing", tag, k), 32'(playing), 32'(e.playing));
                chk($sformatf("%s t%0d music", tag, k), 32'(music_data), 32'(e.music));
                chk($sformatf("%s t%0d done", tag, k), 32'(done), 32'(e.done));
            end
        end
    endtask

    task automatic chk_idle_now(input string tag);
        chk({tag, " playing"}, 32'(playing), 32'd0);
        chk({tag, " music"}, 32'(music_data), 32'h80);
        chk({tag, " rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, " cur_src"}, 32'(cur_src), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int d0;
        logic [7:0] m;

        tbl[0] = '{4'b0111, 8'hF0};
        tbl[1] = '{4'b1111, 8'h10};
        tbl[2] = '{4'b0000, 8'h80};
        tbl[3] = '{4'b1000, 8'h80};
        tbl[4] = '{4'b0001, 8'h90};
        tbl[5] = '{4'b1001, 8'h70};
        tbl[6] = '{4'b0100, 8'hC0};
        tbl[7] = '{4'b1100, 8'h40};
        for (int a = 0; a < 4096; a++) rom_mem[a] = 4'((a * 5 + 3) % 16);
        for (int i = 0; i < 8; i++) rom_mem[i] = tbl[i].word;

        snd_req = 3'b000;
        reset   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_now("reset");
        reset = 1'b0;

        // Single jump
        push_idle(0, 0, 1);
        check_ticks("idle0", 1);
        d0 = done_cnt;
        pulse(3'b010);
        push_start(1, 8'h80, 1'b0);
        push_body(1, 1, 5);
        push_end_idle(1);
        push_idle(1029, 1, 1);
        check_ticks("jump", 8);
        chk("jump done count", 32'(done_cnt - d0), 32'd1);

        // Conversion table through the crash range
        d0 = done_cnt;
        pulse(3'b001);
        wait_tick();
        chk("conv start addr", 32'(rom_addr), 32'd0);
        chk("conv start playing", 32'(playing), 32'd1);
        for (int i = 0; i < 8; i++) begin
            wait_tick();
            chk($sformatf("conv %0d music", i), 32'(music_data), 32'(tbl[i].music));
            chk($sformatf("conv %0d done", i), 32'(done), (i == 7) ? 32'd1 : 32'd0);
        end
        wait_tick();
        chk("conv after music", 32'(music_data), 32'h80);
        chk("conv done count", 32'(done_cnt - d0), 32'd1);

        // Preemption of jump by crash at offset 3
        d0 = done_cnt;
        pulse(3'b010);
        push_start(1, 8'h80, 1'b0);
        push_body(1, 1, 3);
        check_ticks("pre_jump", 4);
        pulse(3'b001);
        push_start(0, rom_conv(1027), 1'b0);
        push_body(0, 1, 7);
        push_end_idle(0);
        push_idle(7, 0, 1);
        check_ticks("pre_crash", 10);
        chk("preempt done count", 32'(done_cnt - d0), 32'd1);

        // Score queued behind crash, chained without a gap
        d0 = done_cnt;
        pulse(3'b001);
        push_start(0, 8'h80, 1'b0);
        push_body(0, 1, 2);
        check_ticks("q_crash", 3);
        pulse(3'b100);
        push_body(0, 3, 7);
        push_start(2, last_mus(0), 1'b1);
        push_body(2, 1, 3);
        push_end_idle(2);
        push_idle(2051, 2, 1);
        check_ticks("q_chain", 11);
        chk("queue done count", 32'(done_cnt - d0), 32'd2);

        // All three at once
        d0 = done_cnt;
        pulse(3'b111);
        push_start(0, 8'h80, 1'b0);
        push_body(0, 1, 7);
        push_start(1, last_mus(0), 1'b1);
        push_body(1, 1, 5);
        push_start(2, last_mus(1), 1'b1);
        push_body(2, 1, 3);
        push_end_idle(2);
        push_idle(2051, 2, 1);
        check_ticks("all3", 20);
        chk("all3 done count", 32'(done_cnt - d0), 32'd3);

        // Held request plays once
        d0 = done_cnt;
        snd_req = 3'b010;
        push_start(1, 8'h80, 1'b0);
        push_body(1, 1, 5);
        push_end_idle(1);
        push_idle(1029, 1, 3);
        check_ticks("hold", 10);
        snd_req = 3'b000;
        push_idle(1029, 1, 2);
        check_ticks("hold_rel", 2);
        chk("hold done count", 32'(done_cnt - d0), 32'd1);

        // Same-source retrigger restarts
        d0 = done_cnt;
        pulse(3'b010);
        push_start(1, 8'h80, 1'b0);
        push_body(1, 1, 2);
        check_ticks("retrig_a", 3);
        pulse(3'b010);
        m = rom_conv(1026);
        push_start(1, m, 1'b0);
        push_body(1, 1, 5);
        push_end_idle(1);
        push_idle(1029, 1, 1);
        check_ticks("retrig_b", 8);
        chk("retrig done count", 32'(done_cnt - d0), 32'd1);

        // Reset mid-play with a request pending
        d0 = done_cnt;
        pulse(3'b001);
        push_start(0, 8'h80, 1'b0);
        push_body(0, 1, 3);
        check_ticks("rst_pre", 4);
        pulse(3'b100);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle_now("midreset");
        reset = 1'b0;
        push_idle(0, 0, 3);
        check_ticks("rst_post", 3);
        chk("reset done count", 32'(done_cnt - d0), 32'd0);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
